// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- load/store unit between the core memory stage and a
// byte-addressable data memory.
//
// Accepts one load/store at a time over a valid/ready handshake. It checks
// funct3 legality, alignment and address range. Legal accesses are issued on
// the memory port, and a held response is returned with data, misalign and
// fault flags.
//
// Optional feature macro: LSU_MISALIGN_SPLIT_EN
//   defined   : misaligned legal accesses are broken into byte accesses (SPLIT)
//   undefined : misaligned legal accesses respond with o_resp_misalign=1
//
// Parameters:
//   MEM_BYTES       data memory size in bytes (range check)
// Ports:
//   i_clk, i_rst_n  clock, synchronous active-low reset
//   i_req_*         request channel (valid/ready, we, funct3, addr, wdata)
//   o_resp_*        response channel (valid/ready, rdata, misalign, fault)
//   o_mem_*         memory strobes, address, write data, size/sign
//   i_mem_rd_data   combinational memory read data
// -----------------------------------------------------------------------------
module lsu_ctrl #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_misalign,
  output logic        o_resp_fault,
  output logic        o_mem_wr_en,
  output logic        o_mem_rd_en,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wr_data,
  output logic [2:0]  o_mem_funct3,
  input  logic [31:0] i_mem_rd_data
);

`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_SPLIT  = 2'd2,
    S_RESP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd3
  } state_t;
`endif

  // Access size in bytes from funct3[1:0].
  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      2'b10:   size_of = 3'd4;
      default: size_of = 3'd4;
    endcase
  endfunction

  // RV32I legality: loads LB/LH/LW/LBU/LHU, stores SB/SH/SW.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      funct3_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    end else begin
      funct3_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                     (f3 == 3'b100) || (f3 == 3'b101);
    end
  endfunction

`ifdef LSU_MISALIGN_SPLIT_EN
  // Final extension of a byte-assembled load (only half/word can be split).
  function automatic logic [31:0] extend_split(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b001:  extend_split = {{16{d[15]}}, d[15:0]};
      3'b101:  extend_split = {16'h0000, d[15:0]};
      3'b010:  extend_split = d;
      default: extend_split = d;
    endcase
  endfunction
`endif

  state_t      r_state;
  state_t      w_next_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_misalign;
  logic        r_fault;

  logic [2:0]  w_size;
  logic        w_legal;
  logic        w_unaligned;
  logic [32:0] w_end;
  logic        w_oor;
  logic        w_fault;
  logic        w_misalign;

  logic        w_mem_wr_en;
  logic        w_mem_rd_en;
  logic [31:0] w_mem_addr;
  logic [31:0] w_mem_wr_data;
  logic [2:0]  w_mem_funct3;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [1:0]  r_cnt;
  logic [2:0]  r_size;
  logic        w_go_split;
  logic        w_split_last;
  logic [31:0] w_split_buf;
  logic [31:0] w_split_data;
`endif

  // Request classification on the live request inputs.
  assign w_size      = size_of(i_req_funct3);
  assign w_legal     = funct3_legal(i_req_we, i_req_funct3);
  assign w_unaligned = ((w_size == 3'd2) && i_req_addr[0]) ||
                       ((w_size == 3'd4) && (i_req_addr[1:0] != 2'b00));
  // Last byte address, 33 bits wide so a wrap past 2^32 is out of range.
  assign w_end       = {1'b0, i_req_addr} + {30'd0, w_size} - 33'd1;
  assign w_oor       = (w_end >= 33'(MEM_BYTES));

`ifdef LSU_MISALIGN_SPLIT_EN
  assign w_fault      = !w_legal || w_oor;
  assign w_misalign   = 1'b0;
  assign w_go_split   = w_legal && !w_oor && w_unaligned;
  assign w_split_last = ({1'b0, r_cnt} == (r_size - 3'd1));
`else
  // Misalignment outranks the range check when splitting is not built.
  assign w_fault    = !w_legal || (!w_unaligned && w_oor);
  assign w_misalign = w_legal && w_unaligned;
`endif

  // Next state and memory-port drive decoded from the current state.
  always_comb begin
    w_next_state  = r_state;
    w_mem_wr_en   = 1'b0;
    w_mem_rd_en   = 1'b0;
    w_mem_addr    = 32'h0000_0000;
    w_mem_wr_data = 32'h0000_0000;
    w_mem_funct3  = 3'b000;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          if (w_fault || w_misalign) begin
            w_next_state = S_RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
          end else if (w_go_split) begin
            w_next_state = S_SPLIT;
`endif
          end else begin
            w_next_state = S_ACCESS;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ACCESS: begin
        w_mem_wr_en   = r_we;
        w_mem_rd_en   = !r_we;
        w_mem_addr    = r_addr;
        w_mem_wr_data = r_wdata;
        w_mem_funct3  = r_funct3;
        w_next_state  = S_RESP;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_SPLIT: begin
        // One byte per cycle at addr+cnt; LBU for loads, SB for stores.
        w_mem_wr_en   = r_we;
        w_mem_rd_en   = !r_we;
        w_mem_addr    = r_addr + {30'd0, r_cnt};
        w_mem_wr_data = {24'h000000, r_wdata[{r_cnt, 3'b000} +: 8]};
        w_mem_funct3  = r_we ? 3'b000 : 3'b100;
        if (w_split_last) begin
          w_next_state = S_RESP;
        end else begin
          w_next_state = S_SPLIT;
        end
      end
`endif
      S_RESP: begin
        if (i_resp_ready) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_RESP;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  // Merge the current byte into the load buffer; extend after the last byte.
  always_comb begin
    w_split_buf = r_rdata;
    w_split_buf[{r_cnt, 3'b000} +: 8] = i_mem_rd_data[7:0];
    if (w_split_last) begin
      w_split_data = extend_split(r_funct3, w_split_buf);
    end else begin
      w_split_data = w_split_buf;
    end
  end
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Request latch, load-data capture and response flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_we       <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr     <= 32'h0000_0000;
      r_wdata    <= 32'h0000_0000;
      r_rdata    <= 32'h0000_0000;
      r_misalign <= 1'b0;
      r_fault    <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_cnt      <= 2'd0;
      r_size     <= 3'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_we       <= i_req_we;
            r_funct3   <= i_req_funct3;
            r_addr     <= i_req_addr;
            r_wdata    <= i_req_wdata;
            r_rdata    <= 32'h0000_0000;
            r_misalign <= w_misalign;
            r_fault    <= w_fault;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_cnt      <= 2'd0;
            r_size     <= w_size;
`endif
          end
        end
        S_ACCESS: begin
          // Memory already extended the load; stores keep rdata at 0.
          if (!r_we) begin
            r_rdata <= i_mem_rd_data;
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        S_SPLIT: begin
          if (!r_we) begin
            r_rdata <= w_split_data;
          end
          r_cnt <= r_cnt + 2'd1;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign o_req_ready     = i_rst_n && (r_state == S_IDLE);
  assign o_resp_valid    = (r_state == S_RESP);
  assign o_resp_rdata    = r_rdata;
  assign o_resp_misalign = r_misalign;
  assign o_resp_fault    = r_fault;
  assign o_mem_wr_en     = w_mem_wr_en;
  assign o_mem_rd_en     = w_mem_rd_en;
  assign o_mem_addr      = w_mem_addr;
  assign o_mem_wr_data   = w_mem_wr_data;
  assign o_mem_funct3    = w_mem_funct3;

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl -- self-checking bench for lsu_ctrl.
// Contains a byte-array data memory acting as the responder and a
// transaction-level reference model with its own shadow memory.
// Honours LSU_MISALIGN_SPLIT_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

  localparam int MEMB = 4096;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic        resp_fault;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rd_data;

  int ncomp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_BYTES(MEMB)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_we        (req_we),
    .i_req_funct3    (req_funct3),
    .i_req_addr      (req_addr),
    .i_req_wdata     (req_wdata),
    .o_resp_valid    (resp_valid),
    .i_resp_ready    (resp_ready),
    .o_resp_rdata    (resp_rdata),
    .o_resp_misalign (resp_misalign),
    .o_resp_fault    (resp_fault),
    .o_mem_wr_en     (mem_wr_en),
    .o_mem_rd_en     (mem_rd_en),
    .o_mem_addr      (mem_addr),
    .o_mem_wr_data   (mem_wr_data),
    .o_mem_funct3    (mem_funct3),
    .i_mem_rd_data   (mem_rd_data)
  );

  // ---------------- data memory responder ----------------
  logic [7:0]  dmem [0:MEMB-1];
  logic        init_done = 1'b0;
  logic [11:0] a0, a1, a2, a3;
  int          wr_cyc = 0;
  int          rd_cyc = 0;
  logic [2:0]  last_f3 = 3'b000;
  logic [31:0] last_addr = 32'h0;

  assign a0 = mem_addr[11:0];
  assign a1 = a0 + 12'd1;
  assign a2 = a0 + 12'd2;
  assign a3 = a0 + 12'd3;

  always_comb begin
    case (mem_funct3)
      3'b000:  mem_rd_data = {{24{dmem[a0][7]}}, dmem[a0]};
      3'b100:  mem_rd_data = {24'h0, dmem[a0]};
      3'b001:  mem_rd_data = {{16{dmem[a1][7]}}, dmem[a1], dmem[a0]};
      3'b101:  mem_rd_data = {16'h0, dmem[a1], dmem[a0]};
      default: mem_rd_data = {dmem[a3], dmem[a2], dmem[a1], dmem[a0]};
    endcase
  end

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < MEMB; i++) dmem[i] <= 8'(i * 7 + 3);
    end else if (mem_wr_en) begin
      dmem[a0] <= mem_wr_data[7:0];
      if (mem_funct3[1:0] != 2'b00) dmem[a1] <= mem_wr_data[15:8];
      if (mem_funct3[1:0] == 2'b10) begin
        dmem[a2] <= mem_wr_data[23:16];
        dmem[a3] <= mem_wr_data[31:24];
      end
    end
    if (mem_wr_en) wr_cyc <= wr_cyc + 1;
    if (mem_rd_en) rd_cyc <= rd_cyc + 1;
    if (mem_wr_en || mem_rd_en) begin
      last_f3   <= mem_funct3;
      last_addr <= mem_addr;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [0:MEMB-1];

  task automatic model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] wd, output bit [31:0] rd, output bit mis,
                       output bit flt, output int lat, output int nwr, output int nrd,
                       output bit [2:0] ef3, output bit [31:0] eaddr);
    int        n;
    bit        legal, unal;
    bit [63:0] last;
    bit [31:0] v;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    unal  = (addr % n) != 0;
    last  = 64'(addr) + 64'(n) - 64'd1;
    rd = 0; mis = 0; flt = 0; lat = 0; nwr = 0; nrd = 0; ef3 = 0; eaddr = 0;
    if (!legal) flt = 1;
    else if (unal && !SPLIT_EN) mis = 1;
    else if (last >= 64'(MEMB)) flt = 1;
    else begin
      if (unal) begin
        lat = n; ef3 = we ? 3'd0 : 3'd4; eaddr = addr + n - 1;
      end else begin
        lat = 1; ef3 = f3; eaddr = addr;
      end
      if (we) nwr = lat; else nrd = lat;
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[addr + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
        case (f3)
          3'd0:    rd = {{24{v[7]}}, v[7:0]};
          3'd4:    rd = v & 32'hFF;
          3'd1:    rd = {{16{v[15]}}, v[15:0]};
          3'd5:    rd = v & 32'hFFFF;
          default: rd = v;
        endcase
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    ncomp++;
    assert (act === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  // One full transaction: issue, wait for response, optional backpressure.
  task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [31:0] wd, input int hold, input string tag);
    bit [31:0] erd, eaddr;
    bit        emis, eflt;
    bit [2:0]  ef3;
    int        elat, enwr, enrd, w0, r0, k;
    model(we, f3, addr, wd, erd, emis, eflt, elat, enwr, enrd, ef3, eaddr);
    @(negedge clk);
    chk({tag, "/req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    w0 = wr_cyc; r0 = rd_cyc;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "/latency"}, 32'(k), 32'(elat));
    chk({tag, "/rdata"}, resp_rdata, erd);
    chk({tag, "/misalign"}, 32'(resp_misalign), 32'(emis));
    chk({tag, "/fault"}, 32'(resp_fault), 32'(eflt));
    chk({tag, "/wr_cycles"}, 32'(wr_cyc - w0), 32'(enwr));
    chk({tag, "/rd_cycles"}, 32'(rd_cyc - r0), 32'(enrd));
    if (enwr + enrd > 0) begin
      chk({tag, "/mem_funct3"}, 32'(last_f3), 32'(ef3));
      chk({tag, "/mem_addr"}, last_addr, eaddr);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "/hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, "/hold_rdata"}, resp_rdata, erd);
      chk({tag, "/hold_flags"}, {30'd0, resp_misalign, resp_fault}, {30'd0, emis, eflt});
      chk({tag, "/hold_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, "/resp_done"}, 32'(resp_valid), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit        rwe;
    bit [2:0]  rf3;
    bit [31:0] raddr;
    int        sel;
    for (int i = 0; i < MEMB; i++) ref_mem[i] = 8'(i * 7 + 3);
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    @(negedge clk);
    init_done = 1'b1;
    @(negedge clk);
    chk("reset/req_ready", 32'(req_ready), 32'd0);
    chk("reset/resp_valid", 32'(resp_valid), 32'd0);
    chk("reset/strobes", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
    chk("reset/rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset/release_ready", 32'(req_ready), 32'd1);

    do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, "sw100");
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 0, "lw100");
    do_req(1'b0, 3'b000, 32'h103, 32'h0, 0, "lb103");
    do_req(1'b0, 3'b100, 32'h103, 32'h0, 0, "lbu103");
    do_req(1'b0, 3'b001, 32'h102, 32'h0, 0, "lh102");
    do_req(1'b0, 3'b101, 32'h100, 32'h0, 0, "lhu100");
    do_req(1'b0, 3'b010, 32'h101, 32'h0, 0, "lw101");
    do_req(1'b1, 3'b010, 32'hFFE, 32'h12345678, 0, "sw_ffe");
    do_req(1'b0, 3'b011, 32'h100, 32'h0, 0, "ld_f3_011");
    do_req(1'b1, 3'b100, 32'h100, 32'h0, 0, "st_f3_100");
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 3, "backpressure");

    // Reset while a load is in flight.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h104;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    chk("midreset/ready_low", 32'(req_ready), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("midreset/ready", 32'(req_ready), 32'd0);
      chk("midreset/resp_valid", 32'(resp_valid), 32'd0);
      chk("midreset/strobes", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset/release_ready", 32'(req_ready), 32'd1);
    chk("midreset/release_valid", 32'(resp_valid), 32'd0);

`ifdef LSU_MISALIGN_SPLIT_EN
    // Abort a split store: bytes 0 and 1 commit, bytes 2 and 3 do not.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h121; req_wdata = 32'hA1B2C3D4;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort/resp_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort/no_resp", 32'(resp_valid), 32'd0);
    ref_mem[12'h121] = 8'hD4;
    ref_mem[12'h122] = 8'hC3;
    for (int b = 0; b < 4; b++) do_req(1'b0, 3'b100, 32'h121 + 32'(b), 32'h0, 0, "abort_lbu");
`endif

    for (int t = 0; t < 80; t++) begin
      rwe = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      sel = int'($urandom_range(0, 9));
      if (sel < 7)      raddr = 32'h100 + 32'($urandom_range(0, 63));
      else if (sel < 9) raddr = 32'hFF8 + 32'($urandom_range(0, 7));
      else              raddr = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      do_req(rwe, rf3, raddr, $urandom, int'($urandom_range(0, 2)), $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
